// File: rtl/heap_sort_ctrl_pkg.sv
// Shared definitions for the heap priority-queue controller: FSM encoding,
// default sizing and the tree index helpers used by sift-up and sift-down.
package heap_sort_pkg;

  localparam int DEPTH_DEF  = 10;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SIFT_UP   = 2'd1,
    SIFT_DOWN = 2'd2
  } state_t;

  // Parent of node i in an array-backed binary tree; only used for i >= 1.
  function automatic int parent_idx(input int i);
    return (i - 1) >> 1;
  endfunction

  function automatic int left_idx(input int i);
    return 2 * i + 1;
  endfunction

  function automatic int right_idx(input int i);
    return 2 * i + 2;
  endfunction

endpackage

// File: rtl/heap_sort_ctrl_if.sv
// Push/pop handshake bundle between the sort front-end, the heap controller
// and the sorted-output consumer.
// Handshakes: a push transfers on the edge where push_valid && push_ready;
// a pop is accepted on the edge where pop_req && pop_ready, after which
// pop_valid/pop_data hold until the edge where pop_ack && pop_valid.
interface heap_sort_ctrl_if
  import heap_sort_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = $clog2(DEPTH_DEF + 1)
);

  logic              push_valid;
  logic [DATA_W-1:0] push_data;
  logic              push_ready;
  logic              pop_req;
  logic              pop_ready;
  logic              pop_valid;
  logic [DATA_W-1:0] pop_data;
  logic              pop_ack;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              busy;
  state_t            dbgState;

  // Requester side: front-end pushing keys and consumer popping them.
  modport master (
    output push_valid, push_data, pop_req, pop_ack,
    input  push_ready, pop_ready, pop_valid, pop_data,
           count, empty, full, busy, dbgState
  );

  // Heap controller side.
  modport slave (
    input  push_valid, push_data, pop_req, pop_ack,
    output push_ready, pop_ready, pop_valid, pop_data,
           count, empty, full, busy, dbgState
  );

endinterface

// File: rtl/heap_sort_swap_sel.sv
// Sift-down compare step: picks the smallest of node idx and its in-range
// children. Strict compares make ties favour idx, then the left child.
module heap_sort_swap_sel
  import heap_sort_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic [DEPTH*DATA_W-1:0] heapFlat,
  input  logic [CNT_W-1:0]        idx,
  input  logic [CNT_W-1:0]        size,
  output logic [CNT_W-1:0]        swapIdx
);

  // One extra bit so 2*idx+2 cannot wrap before the range compare.
  localparam int IW = CNT_W + 1;

  logic [IW-1:0]     lIdx;
  logic [IW-1:0]     rIdx;
  logic              lValid;
  logic              rValid;
  logic [DATA_W-1:0] lKey;
  logic [DATA_W-1:0] rKey;
  logic [DATA_W-1:0] bestKey;

  // Select swap target among idx, left and right child.
  always_comb begin
    lIdx    = IW'(left_idx(int'(idx)));
    rIdx    = IW'(right_idx(int'(idx)));
    lValid  = lIdx < {1'b0, size};
    rValid  = rIdx < {1'b0, size};
    lKey    = '0;
    rKey    = '0;
    if (lValid) lKey = heapFlat[int'(lIdx)*DATA_W +: DATA_W];
    if (rValid) rKey = heapFlat[int'(rIdx)*DATA_W +: DATA_W];
    swapIdx = idx;
    bestKey = heapFlat[int'(idx)*DATA_W +: DATA_W];
    if (lValid && (lKey < bestKey)) begin
      swapIdx = CNT_W'(lIdx);
      bestKey = lKey;
    end
    if (rValid && (rKey < bestKey)) begin
      swapIdx = CNT_W'(rIdx);
    end
  end

endmodule

// File: rtl/heap_sort_ctrl.sv
// Min-heap priority-queue controller: owns heap storage, accepts pushes and
// pops, and restores heap order one tree level per clock.
module heap_sort_ctrl
  import heap_sort_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic            system1000,
  input  logic            system1000_rstn,
  heap_sort_ctrl_if.slave bus
);

  state_t                  state;
  logic [DATA_W-1:0]       heap [DEPTH];
  logic [CNT_W-1:0]        size;
  logic [CNT_W-1:0]        idx;
  logic [DATA_W-1:0]       popData;
  logic                    popValid;
  logic [DEPTH*DATA_W-1:0] heapFlat;
  logic [CNT_W-1:0]        swapIdx;
  logic [CNT_W-1:0]        parentIdx;
  logic                    popReady;
  logic                    pushReady;
  logic                    popAccept;
  logic                    pushAccept;

  // Pop wins over a simultaneous push, so push_ready drops when a pop goes in.
  assign popReady   = (state == IDLE) && (size != '0) && !popValid;
  assign pushReady  = (state == IDLE) && (size < CNT_W'(DEPTH)) && !(bus.pop_req && popReady);
  assign popAccept  = bus.pop_req && popReady;
  assign pushAccept = bus.push_valid && pushReady;
  assign parentIdx  = CNT_W'(parent_idx(int'(idx)));

  // Flatten storage for the swap-select block.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      heapFlat[i*DATA_W +: DATA_W] = heap[i];
    end
  end

  heap_sort_swap_sel #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) u_swap_sel (
    .heapFlat(heapFlat),
    .idx     (idx),
    .size    (size),
    .swapIdx (swapIdx)
  );

  // Controller FSM: accept requests in IDLE, then sift one level per cycle.
  always_ff @(posedge system1000) begin
    if (!system1000_rstn) begin
      for (int i = 0; i < DEPTH; i++) heap[i] <= '0;
      size     <= '0;
      idx      <= '0;
      popData  <= '0;
      popValid <= 1'b0;
      state    <= IDLE;
    end else begin
      if (popValid && bus.pop_ack) popValid <= 1'b0;
      case (state)
        IDLE: begin
          if (popAccept) begin
            popData  <= heap[0];
            popValid <= 1'b1;
            heap[0]  <= heap[size - CNT_W'(1)];
            size     <= size - CNT_W'(1);
            idx      <= '0;
            // New size of at least 2 means the moved-up leaf may be out of order.
            state    <= (size >= CNT_W'(3)) ? SIFT_DOWN : IDLE;
          end else if (pushAccept) begin
            heap[size] <= bus.push_data;
            idx        <= size;
            size       <= size + CNT_W'(1);
            state      <= (size == '0) ? IDLE : SIFT_UP;
          end
        end
        SIFT_UP: begin
          if (heap[idx] < heap[parentIdx]) begin
            heap[idx]       <= heap[parentIdx];
            heap[parentIdx] <= heap[idx];
            idx             <= parentIdx;
            state           <= (parentIdx != '0) ? SIFT_UP : IDLE;
          end else begin
            state <= IDLE;
          end
        end
        SIFT_DOWN: begin
          if (swapIdx != idx) begin
            heap[idx]     <= heap[swapIdx];
            heap[swapIdx] <= heap[idx];
            idx           <= swapIdx;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.push_ready = pushReady;
  assign bus.pop_ready  = popReady;
  assign bus.pop_valid  = popValid;
  assign bus.pop_data   = popData;
  assign bus.count      = size;
  assign bus.empty      = (size == '0);
  assign bus.full       = (size == CNT_W'(DEPTH));
  assign bus.busy       = (state != IDLE);
  assign bus.dbgState   = state;

endmodule

// File: tb/tb_heap_sort_ctrl.sv
// Bench for heap_sort_ctrl: directed scenarios plus a randomized push/pop mix
// checked against a multiset model that always returns its minimum key.
module tb_heap_sort_ctrl;
  import heap_sort_pkg::*;

  localparam int DEPTH   = 10;
  localparam int DATA_W  = 16;
  localparam int CNT_W   = 4;
  localparam int MAX_LAT = 4;  // floor(log2(10)) + 1

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  heap_sort_ctrl_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  heap_sort_ctrl #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .system1000     (clk),
    .system1000_rstn(rstn),
    .bus            (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] model_q[$];  // keys currently held, unordered
  logic [DATA_W-1:0] exp_q[$];    // expected pop results in order

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] model_pop_min();
    int mi = 0;
    for (int i = 1; i < model_q.size(); i++) begin
      if (model_q[i] < model_q[mi]) mi = i;
    end
    model_pop_min = model_q[mi];
    model_q.delete(mi);
  endfunction

  // ---------------- driver tasks (all driving at negedge) ----------------
  task automatic wait_idle();
    int n = 0;
    while ((bus.busy !== 1'b0) && (n < 50)) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 32'(bus.busy), 32'd0);
  endtask

  task automatic do_push(input logic [DATA_W-1:0] key, output int cyc);
    wait_idle();
    bus.push_valid = 1'b1;
    bus.push_data  = key;
    #1;
    chk("push_ready", 32'(bus.push_ready), 32'd1);
    @(negedge clk);
    bus.push_valid = 1'b0;
    model_q.push_back(key);
    cyc = 0;
    while ((bus.busy === 1'b1) && (cyc < 50)) begin
      cyc++;
      @(negedge clk);
    end
    chk("push_latency", 32'(cyc <= MAX_LAT), 32'd1);
    chk("count_after_push", 32'(bus.count), 32'(model_q.size()));
  endtask

  task automatic ack_pop();
    bus.pop_ack = 1'b1;
    @(negedge clk);
    bus.pop_ack = 1'b0;
    chk("pop_valid_clear", 32'(bus.pop_valid), 32'd0);
  endtask

  task automatic do_pop(output int cyc);
    logic [DATA_W-1:0] exp_key;
    wait_idle();
    bus.pop_req = 1'b1;
    #1;
    chk("pop_ready", 32'(bus.pop_ready), 32'd1);
    @(negedge clk);
    bus.pop_req = 1'b0;
    exp_q.push_back(model_pop_min());
    exp_key = exp_q.pop_front();
    chk("pop_valid_rise", 32'(bus.pop_valid), 32'd1);
    chk("pop_data", 32'(bus.pop_data), 32'(exp_key));
    chk("count_after_pop", 32'(bus.count), 32'(model_q.size()));
    cyc = 0;
    while ((bus.busy === 1'b1) && (cyc < 50)) begin
      cyc++;
      @(negedge clk);
      chk("pop_valid_hold", 32'(bus.pop_valid), 32'd1);
      chk("pop_data_hold", 32'(bus.pop_data), 32'(exp_key));
    end
    chk("pop_latency", 32'(cyc <= MAX_LAT), 32'd1);
    ack_pop();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    bus.push_valid = 1'b0;
    bus.push_data  = '0;
    bus.pop_req    = 1'b0;
    bus.pop_ack    = 1'b0;

    // Reset held with a push request pending.
    rstn           = 1'b0;
    bus.push_valid = 1'b1;
    bus.push_data  = 16'd123;
    repeat (3) @(negedge clk);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_pop_ready", 32'(bus.pop_ready), 32'd0);
    rstn           = 1'b1;
    bus.push_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_count", 32'(bus.count), 32'd0);
    chk("post_rst_empty", 32'(bus.empty), 32'd1);
    chk("post_rst_full", 32'(bus.full), 32'd0);
    chk("post_rst_pop_ready", 32'(bus.pop_ready), 32'd0);
    chk("post_rst_push_ready", 32'(bus.push_ready), 32'd1);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);

    // Small heap: 10 must climb two levels to the root.
    do_push(16'd50, cyc);
    do_push(16'd30, cyc);
    do_push(16'd40, cyc);
    do_push(16'd10, cyc);
    chk("sift_up_cycles_10", 32'(cyc), 32'd2);
    chk("count_4", 32'(bus.count), 32'd4);
    repeat (4) do_pop(cyc);
    chk("empty_after_drain", 32'(bus.empty), 32'd1);

    // Fill with descending keys, then stall an extra push.
    for (int k = 9; k >= 0; k--) do_push(16'(k), cyc);
    chk("full_set", 32'(bus.full), 32'd1);
    bus.push_valid = 1'b1;
    bus.push_data  = 16'd77;
    repeat (3) begin
      #1;
      chk("full_push_ready", 32'(bus.push_ready), 32'd0);
      @(negedge clk);
      chk("full_count_hold", 32'(bus.count), 32'd10);
    end
    bus.push_valid = 1'b0;
    repeat (10) do_pop(cyc);
    chk("empty_after_full_drain", 32'(bus.empty), 32'd1);

    // Simultaneous pop and push: only the pop goes in.
    do_push(16'd5, cyc);
    do_push(16'd7, cyc);
    wait_idle();
    bus.pop_req    = 1'b1;
    bus.push_valid = 1'b1;
    bus.push_data  = 16'd1;
    #1;
    chk("prio_pop_ready", 32'(bus.pop_ready), 32'd1);
    chk("prio_push_ready", 32'(bus.push_ready), 32'd0);
    @(negedge clk);
    bus.pop_req    = 1'b0;
    bus.push_valid = 1'b0;
    chk("prio_pop_data", 32'(bus.pop_data), 32'(model_pop_min()));
    chk("prio_count", 32'(bus.count), 32'd1);
    ack_pop();
    do_push(16'd1, cyc);
    do_pop(cyc);
    do_pop(cyc);

    // Equal keys never swap on sift-down.
    repeat (4) do_push(16'd20, cyc);
    do_pop(cyc);
    chk("tie_busy_cycles", 32'(cyc), 32'd1);
    chk("tie_count", 32'(bus.count), 32'd3);
    repeat (3) do_pop(cyc);

    // Reset in the middle of a sift discards everything.
    do_push(16'd8, cyc);
    do_push(16'd6, cyc);
    do_push(16'd4, cyc);
    wait_idle();
    bus.push_valid = 1'b1;
    bus.push_data  = 16'd1;
    @(negedge clk);
    bus.push_valid = 1'b0;
    chk("mid_sift_busy", 32'(bus.busy), 32'd1);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    model_q.delete();
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_count", 32'(bus.count), 32'd0);
    chk("abort_empty", 32'(bus.empty), 32'd1);
    do_push(16'd3, cyc);
    do_pop(cyc);

    // Randomized mix with small keys so ties are frequent.
    for (int it = 0; it < 300; it++) begin
      if (model_q.size() == 0) begin
        do_push(16'($urandom_range(0, 31)), cyc);
      end else if (model_q.size() == DEPTH) begin
        do_pop(cyc);
      end else if ($urandom_range(0, 1) == 0) begin
        do_push(16'($urandom_range(0, 31)), cyc);
      end else begin
        do_pop(cyc);
      end
    end
    while (model_q.size() > 0) do_pop(cyc);
    chk("final_empty", 32'(bus.empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
